// File: rtl/arm_pkg.sv
// arm_pkg: shared state encoding and address-width helpers for the ARM run controller
package arm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int INS_MEM_SIZE_DEF  = 32;
    localparam int DATA_MEM_SIZE_DEF = 64;

    // Address width for a memory of n words, never narrower than one bit
    function automatic int aw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    localparam int IMEM_AW_DEF = aw(INS_MEM_SIZE_DEF);
    localparam int DMEM_AW_DEF = aw(DATA_MEM_SIZE_DEF);

endpackage

// File: rtl/arm_run_cmp.sv
// arm_run_cmp: registered data compare with one-cycle mismatch pulse and saturating error count
module arm_run_cmp import arm_pkg::*; #(
    parameter int DATA_MEM_SIZE = DATA_MEM_SIZE_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic                             en,
    input  logic [31:0]                      act,
    input  logic [31:0]                      want,
    input  logic [aw(DATA_MEM_SIZE)-1:0]     addr,
    output logic                             miss,
    output logic                             mis_valid,
    output logic [aw(DATA_MEM_SIZE)-1:0]     mis_addr,
    output logic [aw(DATA_MEM_SIZE+1)-1:0]   err_cnt
);

    localparam int ECW = aw(DATA_MEM_SIZE + 1);

    assign miss = en && act != want;

    // Report a mismatch one cycle after the compare and count it, stopping at DATA_MEM_SIZE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_valid <= 1'b0;
            mis_addr  <= '0;
            err_cnt   <= '0;
        end else begin
            mis_valid <= miss;
            if (miss) mis_addr <= addr;
            if (clr) err_cnt <= '0;
            else if (miss && err_cnt != ECW'(DATA_MEM_SIZE)) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/arm_run_ctrl.sv
// arm_run_ctrl: loads a program, runs the ARM core until pc leaves imem, then checks dmem against an expected stream
// Optional watchdog (run_cnt, timeout port) enabled by defining ARM_RUN_WATCHDOG_EN.
module arm_run_ctrl import arm_pkg::*; #(
    parameter int INS_MEM_SIZE   = INS_MEM_SIZE_DEF,
    parameter int DATA_MEM_SIZE  = DATA_MEM_SIZE_DEF,
    parameter int MAX_RUN_CYCLES = 4096
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             ld_valid,
    output logic                             ld_ready,
    input  logic [31:0]                      ld_data,
    output logic                             imem_we,
    output logic [aw(INS_MEM_SIZE)-1:0]      imem_addr,
    output logic [31:0]                      imem_wdata,
    output logic                             cpu_rst,
    input  logic [31:0]                      pc,
    output logic [aw(DATA_MEM_SIZE)-1:0]     dmem_addr,
    input  logic [31:0]                      dmem_rdata,
    input  logic                             exp_valid,
    output logic                             exp_ready,
    input  logic [31:0]                      exp_data,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [aw(DATA_MEM_SIZE+1)-1:0]   err_cnt,
    output logic                             mis_valid,
    output logic [aw(DATA_MEM_SIZE)-1:0]     mis_addr
`ifdef ARM_RUN_WATCHDOG_EN
    ,
    output logic                             timeout
`endif
);

    localparam int          IAW    = aw(INS_MEM_SIZE);
    localparam int          DAW    = aw(DATA_MEM_SIZE);
    localparam logic [31:0] PC_END = 32'(INS_MEM_SIZE * 4);

    state_t         state;
    logic           rst_sync;
    logic [IAW-1:0] ld_cnt;
    logic [DAW-1:0] chk_cnt;
    logic           miss;
    logic           clr;
    logic           wd;
    logic           tmo;

    assign clr        = start && (state == S_IDLE || state == S_DONE);
    assign imem_we    = ld_valid && ld_ready;
    assign imem_addr  = ld_cnt;
    assign imem_wdata = ld_ready ? ld_data : '0;
    assign dmem_addr  = chk_cnt;

    // Reset asserts immediately but releases only on a clock edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 1'b0;
        else rst_sync <= 1'b1;
    end

`ifdef ARM_RUN_WATCHDOG_EN
    localparam int RCW = aw(MAX_RUN_CYCLES);
    logic [RCW-1:0] run_cnt;
    assign wd  = run_cnt == RCW'(MAX_RUN_CYCLES - 1);
    assign tmo = timeout;
    // Count RUN cycles while the core is still inside imem; expiry latches timeout until the next start
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            run_cnt <= '0;
            timeout <= 1'b0;
        end else if (clr) begin
            run_cnt <= '0;
            timeout <= 1'b0;
        end else if (state == S_RUN && pc < PC_END) begin
            if (wd) timeout <= 1'b1;
            else run_cnt <= run_cnt + 1'b1;
        end
    end
`else
    assign wd  = 1'b0;
    assign tmo = 1'b0;
`endif

    // Sequencer: load -> run -> check -> done, all status outputs registered
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state     <= S_IDLE;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            ld_ready  <= 1'b0;
            exp_ready <= 1'b0;
            ld_cnt    <= '0;
            chk_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    state    <= S_LOAD;
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    pass     <= 1'b0;
                    ld_ready <= 1'b1;
                    ld_cnt   <= '0;
                    chk_cnt  <= '0;
                end
                S_LOAD: if (imem_we) begin
                    if (ld_cnt == IAW'(INS_MEM_SIZE - 1)) begin
                        state    <= S_RUN;
                        ld_ready <= 1'b0;
                        cpu_rst  <= 1'b0;
                    end else ld_cnt <= ld_cnt + 1'b1;
                end
                S_RUN: if (pc >= PC_END || wd) begin
                    state     <= S_CHECK;
                    cpu_rst   <= 1'b1;
                    exp_ready <= 1'b1;
                end
                S_CHECK: if (exp_valid) begin
                    if (chk_cnt == DAW'(DATA_MEM_SIZE - 1)) begin
                        state     <= S_DONE;
                        exp_ready <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= err_cnt == '0 && !miss && !tmo;
                    end else chk_cnt <= chk_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    arm_run_cmp #(.DATA_MEM_SIZE(DATA_MEM_SIZE)) u_cmp (
        .clk       (clk),
        .rst       (rst_sync),
        .clr       (clr),
        .en        (exp_valid && exp_ready),
        .act       (dmem_rdata),
        .want      (exp_data),
        .addr      (chk_cnt),
        .miss      (miss),
        .mis_valid (mis_valid),
        .mis_addr  (mis_addr),
        .err_cnt   (err_cnt)
    );

endmodule

// File: tb/tb_arm_run_ctrl.sv
// tb_arm_run_ctrl: randomized self-checking bench with a phase-level reference model
module tb_arm_run_ctrl;

    localparam int IMS = 32;
    localparam int DMS = 64;
`ifdef ARM_RUN_WATCHDOG_EN
    localparam int MRC = 16;
`else
    localparam int MRC = 4096;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic [31:0] pc = '0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_data = '0;
    logic        ld_ready, imem_we, cpu_rst, exp_ready, busy, done, pass, mis_valid;
    logic [31:0] imem_wdata, dmem_rdata;
    logic [4:0]  imem_addr;
    logic [5:0]  dmem_addr, mis_addr;
    logic [6:0]  err_cnt;
`ifdef ARM_RUN_WATCHDOG_EN
    logic        timeout;
`endif

    logic [31:0] dmem [DMS];
    logic [31:0] prog [IMS];
    logic [31:0] imem_cap [IMS];
    bit          flip [DMS];
    int          misq [$];
    int          rcyc = 0;
    int          total = 0;
    int          bad = 0;

    assign dmem_rdata = dmem[dmem_addr];

    always #5 clk = ~clk;

    arm_run_ctrl #(.INS_MEM_SIZE(IMS), .DATA_MEM_SIZE(DMS), .MAX_RUN_CYCLES(MRC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .pc         (pc),
        .dmem_addr  (dmem_addr),
        .dmem_rdata (dmem_rdata),
        .exp_valid  (exp_valid),
        .exp_ready  (exp_ready),
        .exp_data   (exp_data),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .mis_valid  (mis_valid),
        .mis_addr   (mis_addr)
`ifdef ARM_RUN_WATCHDOG_EN
        ,
        .timeout    (timeout)
`endif
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    // Reference model: phase 0 idle, 1 load, 2 run, 3 check, 4 done
    int mode = 0, lc = 0, cc = 0, ec = 0, rc = 0, mma = 0;
    bit rq = 0, mto = 0, mpass = 0, mmv = 0;

    always @(posedge clk) begin
        if (imem_we === 1'b1) imem_cap[imem_addr] = imem_wdata;
        if (!rst) begin
            mode = 0; lc = 0; cc = 0; ec = 0; rc = 0; mma = 0;
            rq = 0; mto = 0; mpass = 0; mmv = 0;
        end else if (!rq) begin
            rq = 1;
        end else begin
            mmv = 0;
            case (mode)
                0, 4: if (start) begin
                    mode = 1; lc = 0; cc = 0; ec = 0; rc = 0; mto = 0; mpass = 0;
                end
                1: if (ld_valid) begin
                    if (lc == IMS - 1) mode = 2;
                    else lc++;
                end
                2: begin
                    if (pc >= IMS * 4) mode = 3;
`ifdef ARM_RUN_WATCHDOG_EN
                    else if (rc == MRC - 1) begin mode = 3; mto = 1; end
                    else rc++;
`endif
                end
                3: if (exp_valid) begin
                    if (dmem[cc] !== exp_data) begin
                        mmv = 1; mma = cc;
                        if (ec < DMS) ec++;
                    end
                    if (cc == DMS - 1) begin mode = 4; mpass = ec == 0 && !mto; end
                    else cc++;
                end
                default: mode = 0;
            endcase
        end
        #1;
        chk("cpu_rst", cpu_rst, mode != 2);
        chk("busy", busy, mode inside {1, 2, 3});
        chk("done", done, mode == 4);
        chk("pass", pass, mode == 4 && mpass);
        chk("ld_ready", ld_ready, mode == 1);
        chk("exp_ready", exp_ready, mode == 3);
        chk("imem_we", imem_we, ld_valid && mode == 1);
        chk("imem_addr", imem_addr, lc);
        if (mode == 1) chk("imem_wdata", imem_wdata, ld_data);
        chk("dmem_addr", dmem_addr, cc);
        chk("err_cnt", err_cnt, ec);
        chk("mis_valid", mis_valid, mmv);
        if (mmv) chk("mis_addr", mis_addr, mma);
`ifdef ARM_RUN_WATCHDOG_EN
        chk("timeout", timeout, mto);
`endif
        if (mis_valid === 1'b1) misq.push_back(int'(mis_addr));
        if (cpu_rst === 1'b0) rcyc++;
    end

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic new_prog;
        for (int i = 0; i < IMS; i++) prog[i] = $urandom;
        for (int i = 0; i < DMS; i++) begin dmem[i] = $urandom; flip[i] = 0; end
    endtask

    task automatic load(input bit rnd, input bit inj, input int nw);
        int  i = 0;
        int  cyc = 0;
        bit  acc;
        while (i < nw && cyc < 1000) begin
            ld_valid = rnd ? $urandom_range(0, 2) != 0 : cyc % 3 != 2;
            ld_data  = prog[i];
            start    = inj && cyc == 5;
            acc      = ld_valid && ld_ready;
            @(negedge clk);
            if (acc) i++;
            cyc++;
        end
        ld_valid = 1'b0;
        start    = 1'b0;
        if (i < nw) chk("load_bound", i, nw);
    endtask

    task automatic run_rand(input int n);
        for (int k = 0; k < n; k++) begin
            pc = 32'($urandom_range(0, IMS - 1)) << 2;
            @(negedge clk);
        end
        pc = 32'(IMS * 4) + 32'($urandom_range(0, 255));
        @(negedge clk);
        pc = '0;
    endtask

    task automatic feed;
        int  i = 0;
        int  cyc = 0;
        bit  acc;
        while (i < DMS && cyc < 2000) begin
            exp_valid = $urandom_range(0, 3) != 0;
            exp_data  = dmem[i] ^ (flip[i] ? ($urandom | 32'd1) : 32'd0);
            acc       = exp_valid && exp_ready;
            @(negedge clk);
            if (acc) i++;
            cyc++;
        end
        exp_valid = 1'b0;
        if (i < DMS) chk("check_bound", i, DMS);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int m0, r0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b1;
        pulse_start;
        chk("early_start_ignored", busy, 0);

        new_prog;
        pulse_start;
        load(0, 0, 10);
        #2 rst = 1'b0;
        #1;
        chk("midload_cpu_rst", cpu_rst, 1);
        chk("midload_ld_ready", ld_ready, 0);
        chk("midload_err_cnt", err_cnt, 0);
        chk("midload_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        new_prog;
        flip[5] = 1;
        flip[63] = 1;
        m0 = misq.size();
        pulse_start;
        load(0, 0, IMS);
        chk("run_entered", cpu_rst, 0);
        for (int i = 0; i < IMS; i++) chk("imem_word", imem_cap[i], prog[i]);
        pc = 32'h78;
        @(negedge clk);
        pc = 32'h7C;
        @(negedge clk);
        pc = 32'h80;
        @(posedge clk);
        #1;
        chk("pc_exit_cpu_rst", cpu_rst, 1);
        chk("pc_exit_exp_ready", exp_ready, 1);
        @(negedge clk);
        pc = '0;
        feed;
        chk("mis_count", misq.size() - m0, 2);
        if (misq.size() - m0 == 2) begin
            chk("mis_first", misq[m0], 5);
            chk("mis_second", misq[m0 + 1], 63);
        end
        chk("two_err_cnt", err_cnt, 2);
        chk("two_done", done, 1);
        chk("two_pass", pass, 0);

        new_prog;
        pulse_start;
        chk("restart_busy", busy, 1);
        chk("restart_ld_ready", ld_ready, 1);
        chk("restart_err_cnt", err_cnt, 0);
        chk("restart_imem_addr", imem_addr, 0);
        load(1, 1, IMS);
        run_rand(5);
        feed;
        chk("clean_err_cnt", err_cnt, 0);
        chk("clean_pass", pass, 1);

        new_prog;
        for (int i = 0; i < DMS; i++) flip[i] = 1;
        pulse_start;
        load(1, 0, IMS);
        run_rand(2);
        feed;
        chk("sat_err_cnt", err_cnt, DMS);
        chk("sat_pass", pass, 0);

        for (int r = 0; r < 3; r++) begin
            new_prog;
            for (int i = 0; i < DMS; i++) flip[i] = $urandom_range(0, 7) == 0;
            pulse_start;
            load(1, r == 1, IMS);
            run_rand($urandom_range(0, 8));
            feed;
        end

`ifdef ARM_RUN_WATCHDOG_EN
        new_prog;
        r0 = rcyc;
        pulse_start;
        load(1, 0, IMS);
        pc = 32'h10;
        feed;
        pc = '0;
        chk("wd_run_cycles", rcyc - r0, 16);
        chk("wd_timeout", timeout, 1);
        chk("wd_pass", pass, 0);
        pulse_start;
        chk("wd_timeout_cleared", timeout, 0);
`else
        r0 = rcyc;
        m0 = r0;
`endif
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
